ero_trng_ctrl: RTL and testbench

//  Sequencer for the ERO TRNG: gates ring oscillators via ro_en, waits a warm-up time, samples the

---
 rtl/ero_trng_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ero_trng_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ero_trng_ctrl.sv
// Sequencer for the ERO TRNG: warms up the ring oscillators, samples the synchronised raw bit on a
// fixed tick, optionally von Neumann debiases, runs a repetition-count health test and packs words.
module ero_trng_ctrl #(
  parameter int W          = 32,
  parameter int WARMUP_CYC = 1024,
  parameter int SAMPLE_DIV = 64,
  parameter int REP_LIMIT  = 32,
  parameter int VN_EN      = 1
) (
  input  logic         clk_in,
  input  logic         rst_,
  input  logic         en,
  input  logic         prn_in,
  input  logic         rdy_in,
  output logic         ro_en,
  output logic [W-1:0] data_out,
  output logic         valid,
  output logic         busy,
  output logic         fail,
  output logic [2:0]   dbg_state
);

  // Handshake: a word transfers on any clk_in edge where valid && rdy_in; valid never drops
  // before that edge and data_out does not change while valid is high.

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

  localparam int CNT_MAX = (WARMUP_CYC > SAMPLE_DIV) ? WARMUP_CYC : SAMPLE_DIV;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int RW      = $clog2(REP_LIMIT + 1);
  localparam int BW      = $clog2(W);

  localparam logic [CW-1:0] WU_LAST  = CW'(WARMUP_CYC - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_rep;
  logic          r_prev;
  logic          r_phase;
  logic          r_a;
  logic [BW-1:0] r_bcnt;
  logic [W-2:0]  r_shreg;
  logic [W-1:0]  r_data;
  logic          r_ro_en, r_valid, r_busy, r_fail;

  logic          w_tick;
  logic [RW-1:0] w_rep_nxt;
  logic          w_rep_trip;
  logic          w_accept;
  logic          w_bit;
  logic          w_last;
  logic [W-1:0]  w_word;

  assign ro_en     = r_ro_en;
  assign data_out  = r_data;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign fail      = r_fail;
  assign dbg_state = r_state;

  always_ff @(posedge clk_in or posedge rst_) begin
    if (rst_) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= prn_in;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_tick     = (r_state == ST_COLLECT) && (r_cnt == DIV_LAST);
    w_rep_nxt  = (r_sync2 == r_prev) ? r_rep + 1'b1 : RW'(1);
    w_rep_trip = w_tick && (w_rep_nxt == REP_MAX);
    w_accept   = w_tick;
    w_bit      = r_sync2;
    if (VN_EN != 0) begin
      // Second sample of a pair: keep the first one only when the two differ.
      w_accept = w_tick && r_phase && (r_a != r_sync2);
      w_bit    = r_a;
    end
    w_word = {r_shreg, w_bit};
    w_last = w_accept && (r_bcnt == BIT_LAST);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (en) w_state_nxt = ST_WARMUP;
      ST_WARMUP: begin
        if (!en)                    w_state_nxt = ST_IDLE;
        else if (r_cnt == WU_LAST)  w_state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!en)             w_state_nxt = ST_IDLE;
        else if (w_rep_trip) w_state_nxt = ST_FAIL;
        else if (w_last)     w_state_nxt = ST_OUTPUT;
      end
      ST_OUTPUT:  if (r_valid && rdy_in) w_state_nxt = en ? ST_COLLECT : ST_IDLE;
      ST_FAIL:    if (!en) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_) begin
    if (rst_) begin
      r_state <= ST_IDLE;
      r_ro_en <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ro_en <= (w_state_nxt == ST_WARMUP) || (w_state_nxt == ST_COLLECT) ||
                 (w_state_nxt == ST_OUTPUT);
      r_valid <= (w_state_nxt == ST_OUTPUT);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_fail  <= (w_state_nxt == ST_FAIL);
    end
  end

  always_ff @(posedge clk_in or posedge rst_) begin
    if (rst_) begin
      r_cnt   <= '0;
      r_rep   <= '0;
      r_prev  <= 1'b0;
      r_phase <= 1'b0;
      r_a     <= 1'b0;
      r_bcnt  <= '0;
      r_shreg <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_WARMUP:  r_cnt <= (r_cnt == WU_LAST) ? '0 : r_cnt + 1'b1;
        ST_COLLECT: r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        default:    r_cnt <= '0;
      endcase
      // Repetition history survives OUTPUT so back-to-back words share one health run.
      if (r_state == ST_WARMUP) r_rep <= '0;
      else if (w_tick)          r_rep <= w_rep_nxt;
      if (w_tick) r_prev <= r_sync2;
      r_phase <= (r_state == ST_COLLECT) ? (r_phase ^ w_tick) : 1'b0;
      if (w_tick && !r_phase) r_a <= r_sync2;
      if (r_state != ST_COLLECT) begin
        r_bcnt  <= '0;
        r_shreg <= '0;
      end else if (w_accept) begin
        r_bcnt  <= w_last ? '0 : r_bcnt + 1'b1;
        r_shreg <= w_word[W-2:0];
      end
      if ((r_state == ST_COLLECT) && (w_state_nxt == ST_OUTPUT)) r_data <= w_word;
    end
  end

endmodule

// File: tb/tb_ero_trng_ctrl.sv
// Bench for ero_trng_ctrl: two instances (raw 8-bit words, von Neumann 4-bit words) driven with
// directed and random tick streams; a stream-level reference model fills the expected-word queues.
module tb_ero_trng_ctrl;

  localparam int WU  = 16;
  localparam int DIV = 4;
  localparam int LIM = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] en_v, prn_v, rdy_v;
  logic [1:0] ro_en_v, valid_v, busy_v, fail_v;
  logic [7:0] data_a;
  logic [3:0] data_b;
  logic [2:0] st_a, st_b;

  logic [7:0] exp_qa[$];
  logic [7:0] exp_qb[$];
  bit         raw_q[$];
  logic [7:0] m_words[$];
  int         m_wtick[$];
  int         m_ftick;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  ero_trng_ctrl #(.W(8), .WARMUP_CYC(WU), .SAMPLE_DIV(DIV), .REP_LIMIT(LIM), .VN_EN(0)) u_raw (
    .clk_in(clk), .rst_(rst), .en(en_v[0]), .prn_in(prn_v[0]), .rdy_in(rdy_v[0]),
    .ro_en(ro_en_v[0]), .data_out(data_a), .valid(valid_v[0]), .busy(busy_v[0]),
    .fail(fail_v[0]), .dbg_state(st_a)
  );

  ero_trng_ctrl #(.W(4), .WARMUP_CYC(WU), .SAMPLE_DIV(DIV), .REP_LIMIT(LIM), .VN_EN(1)) u_vn (
    .clk_in(clk), .rst_(rst), .en(en_v[1]), .prn_in(prn_v[1]), .rdy_in(rdy_v[1]),
    .ro_en(ro_en_v[1]), .data_out(data_b), .valid(valid_v[1]), .busy(busy_v[1]),
    .fail(fail_v[1]), .dbg_state(st_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] data_of(input int idx);
    return (idx == 0) ? data_a : {4'h0, data_b};
  endfunction

  task automatic load_bits(input logic [31:0] v, input int n);
    raw_q.delete();
    for (int i = n - 1; i >= 0; i--) raw_q.push_back(v[i]);
  endtask

  task automatic load_random(input int n);
    raw_q.delete();
    for (int i = 0; i < n; i++) raw_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // Stream-level model: tick i of a session sees raw_q[i]; ticks are numbered from the first
  // COLLECT after warm-up and the health run continues across words.
  task automatic model(input int idx);
    int         w, run, nacc;
    logic [7:0] acc;
    bit         take, b;
    w = (idx == 0) ? 8 : 4;
    run = 0; nacc = 0; acc = '0;
    m_words.delete(); m_wtick.delete(); m_ftick = -1;
    for (int i = 0; i < raw_q.size(); i++) begin
      if (i > 0 && raw_q[i] == raw_q[i-1]) run++;
      else run = 1;
      if (run == LIM) begin
        m_ftick = i;
        return;
      end
      if (idx == 0) begin
        take = 1'b1; b = raw_q[i];
      end else begin
        take = 1'b0; b = 1'b0;
        if (i % 2 == 1) begin
          take = (raw_q[i] != raw_q[i-1]);
          b    = raw_q[i-1];
        end
      end
      if (take) begin
        acc = {acc[6:0], b};
        nacc++;
        if (nacc == w) begin
          m_words.push_back(acc);
          m_wtick.push_back(i);
          nacc = 0; acc = '0;
        end
      end
    end
  endtask

  // Full session from IDLE: warm-up, raw_q ticks, handoffs with optional stall, then en=0.
  task automatic run_session(input int idx, input int stall, input int fixed);
    int wi;
    wi = 0;
    model(idx);
    for (int k = 0; k < m_words.size(); k++) begin
      logic [7:0] ew;
      ew = (k == 0 && fixed >= 0) ? fixed[7:0] : m_words[k];
      m_words[k] = ew;
      if (idx == 0) exp_qa.push_back(ew);
      else          exp_qb.push_back(ew);
    end
    rdy_v[idx] = (stall == 0);
    prn_v[idx] = raw_q[0];
    en_v[idx]  = 1'b1;
    wait_edges(1);
    check("ro_en_warmup", 32'(ro_en_v[idx]), 1);
    check("busy_warmup", 32'(busy_v[idx]), 1);
    wait_edges(WU);
    for (int i = 0; i < raw_q.size(); i++) begin
      prn_v[idx] = raw_q[i];
      wait_edges(DIV - 1);
      check("valid_pre_tick", 32'(valid_v[idx]), 0);
      wait_edges(1);
      if (i == m_ftick) begin
        check("fail_trip", 32'(fail_v[idx]), 1);
        check("ro_en_fail", 32'(ro_en_v[idx]), 0);
        check("valid_fail", 32'(valid_v[idx]), 0);
        wait_edges(3);
        check("fail_sticky", 32'(fail_v[idx]), 1);
        check("valid_fail_hold", 32'(valid_v[idx]), 0);
        break;
      end
      if (wi < m_wtick.size() && i == m_wtick[wi]) begin
        check("valid_rise", 32'(valid_v[idx]), 1);
        for (int s = 0; s < stall; s++) begin
          prn_v[idx] = 1'($urandom_range(0, 1));
          wait_edges(1);
          check("valid_hold", 32'(valid_v[idx]), 1);
          check("data_hold", 32'(data_of(idx)), 32'(m_words[wi]));
          check("ro_en_hold", 32'(ro_en_v[idx]), 1);
        end
        rdy_v[idx] = 1'b1;
        wait_edges(1);
        check("valid_drop", 32'(valid_v[idx]), 0);
        check("ro_en_after_xfer", 32'(ro_en_v[idx]), 1);
        rdy_v[idx] = (stall == 0);
        wi++;
      end
    end
    en_v[idx] = 1'b0;
    wait_edges(1);
    check("busy_off", 32'(busy_v[idx]), 0);
    check("ro_en_off", 32'(ro_en_v[idx]), 0);
    check("fail_clear", 32'(fail_v[idx]), 0);
  endtask

  // Scoreboard monitor: a word is consumed on the edge following a negedge with valid && rdy.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_v[0] && rdy_v[0]) begin
        if (exp_qa.size() == 0) check("unexpected_word_raw", 32'(data_a), 32'hFFFF_FFFF);
        else                    check("word_raw", 32'(data_a), 32'(exp_qa.pop_front()));
      end
      if (valid_v[1] && rdy_v[1]) begin
        if (exp_qb.size() == 0) check("unexpected_word_vn", 32'(data_b), 32'hFFFF_FFFF);
        else                    check("word_vn", 32'(data_b), 32'(exp_qb.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1;
    en_v = '0; prn_v = '0; rdy_v = '0;
    #3;
    check("rst_ro_en", 32'(ro_en_v), 0);
    check("rst_valid", 32'(valid_v), 0);
    check("rst_busy", 32'(busy_v), 0);
    check("rst_fail", 32'(fail_v), 0);
    check("rst_data", {20'h0, data_b, data_a}, 0);
    #19 rst = 1'b0;
    wait_edges(2);
    check("idle_state", 32'(st_a), 0);

    // Directed raw word: valid exactly 49 edges after en
    load_bits(32'hB2, 8);
    run_session(0, 0, 8'hB2);

    // Von Neumann directed pairs 01,11,10,00,10,01 -> 4'h6 on the 12th tick
    load_bits(32'h789, 12);
    run_session(1, 0, 8'h06);

    // Stuck-at-1 source: health trip on the 8th tick, which also would complete a word
    load_bits(32'hFF, 8);
    run_session(0, 0, -1);

    // Backpressure: ten stalled cycles per word
    load_random(16);
    run_session(0, 10, -1);

    // en dropped mid-COLLECT, then a full session must see a complete warm-up again
    en_v[0] = 1'b1; rdy_v[0] = 1'b1; prn_v[0] = 1'b1;
    wait_edges(1 + WU);
    for (int i = 0; i < 3; i++) begin
      prn_v[0] = (i % 2 == 0);
      wait_edges(DIV);
    end
    check("busy_mid_collect", 32'(busy_v[0]), 1);
    en_v[0] = 1'b0;
    wait_edges(1);
    check("drop_ro_en", 32'(ro_en_v[0]), 0);
    check("drop_busy", 32'(busy_v[0]), 0);
    check("drop_valid", 32'(valid_v[0]), 0);
    load_random(24);
    run_session(0, 0, -1);

    // Randomized sessions on both instances
    for (int r = 0; r < 4; r++) begin
      load_random(24 + 8 * $urandom_range(0, 2));
      run_session(0, $urandom_range(0, 3), -1);
      load_random(32 + 4 * $urandom_range(0, 4));
      run_session(1, $urandom_range(0, 3), -1);
    end

    // Asynchronous reset while a word is pending in OUTPUT
    en_v[0] = 1'b1; rdy_v[0] = 1'b0;
    prn_v[0] = 1'b1;
    wait_edges(1 + WU);
    for (int i = 0; i < 8; i++) begin
      prn_v[0] = (i % 2 == 0);
      wait_edges(DIV);
    end
    check("pending_valid", 32'(valid_v[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid_v[0]), 0);
    check("async_rst_ro_en", 32'(ro_en_v[0]), 0);
    check("async_rst_busy", 32'(busy_v[0]), 0);
    check("async_rst_data", 32'(data_a), 0);
    check("async_rst_state", 32'(st_a), 0);
    en_v[0] = 1'b0;
    #13 rst = 1'b0;
    wait_edges(2);
    check("post_rst_ro_en", 32'(ro_en_v[0]), 0);

    check("raw_queue_drained", exp_qa.size(), 0);
    check("vn_queue_drained", exp_qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
